// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// halt opcode and default instruction-memory word-address width.
// The HALTED state exists only when FETCH_HALT_EN is defined.
package fetch_unit_pkg;

  localparam int unsigned FETCH_ADDR_W = 8;
  localparam logic [5:0]  HALT_OPCODE  = 6'b111111;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_unit_if.sv
// Control, instruction-memory and output bus of the fetch unit.
// slave: the fetch unit itself; master: the surrounding core/memory.
interface fetch_unit_if;

  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] pc;
  logic [31:0] instruction_in;
  logic [31:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;

  modport master (
    output start, stall, branch_taken, branch_offset, jump, jump_target,
    output instruction_in,
    input  pc, instr_out, pc_out, valid_out
  );

  modport slave (
    input  start, stall, branch_taken, branch_offset, jump, jump_target,
    input  instruction_in,
    output pc, instr_out, pc_out, valid_out
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word addresses to a 1-cycle-latency
// instruction memory, pairs returning data with the address in flight and
// presents registered instr_out/pc_out/valid_out. Supports jump/branch
// redirect and stall with address replay.
// Optional feature: FETCH_HALT_EN (halt on opcode 6'b111111).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter int unsigned ADDR_W   = FETCH_ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.slave     bus
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ONE_A      = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              pend_valid_q;
  logic [31:0]       instr_q;
  logic [15:0]       pc_out_q;
  logic              valid_q;

  logic              redirect_d;
  logic [15:0]       branch_tgt_d;
  logic [15:0]       redirect_tgt_d;
  logic [ADDR_W-1:0] pc_inc_d;

  // Redirect target selection (jump wins) and sequential next address
  always_comb begin
    redirect_d     = bus.jump | bus.branch_taken;
    branch_tgt_d   = pc_out_q + 16'd1 + bus.branch_offset;
    redirect_tgt_d = bus.jump ? bus.jump_target : branch_tgt_d;
    pc_inc_d       = pc_q + ONE_A;
  end

  // Fetch FSM with registered outputs; redirect outranks stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC_A;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pc_q         <= RESET_PC_A;
          pend_valid_q <= 1'b0;
          valid_q      <= 1'b0;
          if (bus.start) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_d) begin
            pc_q         <= redirect_tgt_d[ADDR_W-1:0];
            pend_valid_q <= 1'b0;
            valid_q      <= 1'b0;
          end else if (bus.stall) begin
            // The read in flight is dropped; re-issue its address afterwards
            if (pend_valid_q) pc_q <= pend_pc_q;
            pend_valid_q <= 1'b0;
          end else begin
            pend_pc_q    <= pc_q;
            pend_valid_q <= 1'b1;
            pc_q         <= pc_inc_d;
            if (pend_valid_q) begin
              instr_q  <= bus.instruction_in;
              pc_out_q <= 16'(pend_pc_q);
              valid_q  <= 1'b1;
`ifdef FETCH_HALT_EN
              if (bus.instruction_in[31:26] == HALT_OPCODE) state_q <= ST_HALTED;
`endif
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
`ifdef FETCH_HALT_EN
        ST_HALTED: begin
          valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pc        = 16'(pc_q);
  assign bus.instr_out = instr_q;
  assign bus.pc_out    = pc_out_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 256-word
// registered-read instruction memory model (mem[i] = i*17).
module tb_fetch_unit;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;
  logic [31:0] mem [256];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (16'd0),
    .ADDR_W   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle read latency memory
  always @(posedge clk) bus.instruction_in <= mem[bus.pc[7:0]];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] a);
    logic [7:0] idx;
    idx = a[7:0];
    chk({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd1);
    chk({tag, "_pcout"}, {16'd0, bus.pc_out}, {16'd0, a});
    chk({tag, "_instr"}, bus.instr_out, mem[idx]);
  endtask

  task automatic expect_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
  endtask

  task automatic clear_inputs();
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'd0;
    bus.jump          = 1'b0;
    bus.jump_target   = 16'd0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [15:0] frozen_pc;
    logic        saw_valid;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 17);
    clear_inputs();
    reset = 1'b1;
    repeat (2) step();

    // Reset state
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_pc", {16'd0, bus.pc}, 32'd0);
    chk("rst_pcout", {16'd0, bus.pc_out}, 32'd0);
    chk("rst_instr", bus.instr_out, 32'd0);
    reset = 1'b0;

    // Redirect/stall ignored while idle
    bus.jump = 1'b1; bus.jump_target = 16'h0055; bus.stall = 1'b1;
    step();
    clear_inputs();
    chk("idle_pc", {16'd0, bus.pc}, 32'd0);
    expect_bubble("idle");

    // Start: pc 0,1,2 and first instruction two cycles after pc=0
    do_start();
    chk("run_pc0", {16'd0, bus.pc}, 32'd0);
    expect_bubble("run_c0");
    step();
    chk("run_pc1", {16'd0, bus.pc}, 32'd1);
    expect_bubble("run_c1");
    step();
    chk("run_pc2", {16'd0, bus.pc}, 32'd2);
    expect_out("first", 16'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      expect_out("seq", 16'(k));
    end

    // Backward branch at pc_out=4, offset -2 -> 3
    bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFE;
    step();
    clear_inputs();
    chk("br_pc", {16'd0, bus.pc}, 32'd3);
    expect_bubble("br_b1");
    step();
    expect_bubble("br_b2");
    step();
    expect_out("br_t0", 16'h0003);
    step();
    expect_out("br_t1", 16'h0004);
    step();
    expect_out("br_t2", 16'h0005);

    // Jump at pc_out=5 -> 0x20: two bubbles then 0x20, 0x21
    bus.jump = 1'b1; bus.jump_target = 16'h0020;
    step();
    clear_inputs();
    expect_bubble("jmp_b1");
    step();
    expect_bubble("jmp_b2");
    step();
    expect_out("jmp_t0", 16'h0020);
    step();
    expect_out("jmp_t1", 16'h0021);

    // Jump + branch + stall together: jump wins, stall overridden
    bus.jump = 1'b1; bus.jump_target = 16'h0040;
    bus.branch_taken = 1'b1; bus.branch_offset = 16'h0010;
    bus.stall = 1'b1;
    step();
    clear_inputs();
    chk("prio_pc", {16'd0, bus.pc}, 32'h40);
    expect_bubble("prio_b1");
    step();
    step();
    expect_out("prio_t0", 16'h0040);

    // Reach pc_out=7 via jump to 5
    bus.jump = 1'b1; bus.jump_target = 16'h0005;
    step();
    clear_inputs();
    step();
    step();
    expect_out("pre_st5", 16'h0005);
    step();
    step();
    expect_out("pre_st7", 16'h0007);

    // Stall 3 cycles at pc_out=7: hold, then refill from 8
    bus.stall = 1'b1;
    step();
    chk("st_replay_pc", {16'd0, bus.pc}, 32'd8);
    expect_out("st_h1", 16'h0007);
    step();
    expect_out("st_h2", 16'h0007);
    step();
    expect_out("st_h3", 16'h0007);
    bus.stall = 1'b0;
    step();
    expect_bubble("st_refill");
    step();
    expect_out("st_r8", 16'h0008);
    step();
    expect_out("st_r9", 16'h0009);
    step();
    step();
    step();
    expect_out("st_r12", 16'h000C);

    // Reset mid-stream at pc_out=12
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_bubble("mrst");
    chk("mrst_pc", {16'd0, bus.pc}, 32'd0);
    chk("mrst_pcout", {16'd0, bus.pc_out}, 32'd0);
    repeat (3) step();
    chk("mrst_idle_pc", {16'd0, bus.pc}, 32'd0);
    expect_bubble("mrst_idle");

    // Wrap: jump to 0xFC, pc wraps past 0xFF, branch +1 at 0xFF -> 0x01
    do_start();
    step();
    step();
    expect_out("w_first", 16'h0000);
    bus.jump = 1'b1; bus.jump_target = 16'h00FC;
    step();
    clear_inputs();
    step();
    step();
    expect_out("w_fc", 16'h00FC);
    step();
    step();
    expect_out("w_fe", 16'h00FE);
    chk("w_pc_wrap", {16'd0, bus.pc}, 32'd0);
    step();
    expect_out("w_ff", 16'h00FF);
    bus.branch_taken = 1'b1; bus.branch_offset = 16'h0001;
    step();
    clear_inputs();
    step();
    step();
    expect_out("w_br", 16'h0001);

    // Halt opcode at mem[3]
    mem[3] = 32'hFC000000;
    reset = 1'b1;
    step();
    reset = 1'b0;
    do_start();
    step();
    step();
    expect_out("h_0", 16'h0000);
    step();
    step();
    step();
    expect_out("h_3", 16'h0003);
`ifdef FETCH_HALT_EN
    step();
    expect_bubble("h_after");
    frozen_pc = bus.pc;
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      saw_valid = saw_valid | bus.valid_out;
    end
    chk("h_frozen_pc", {16'd0, bus.pc}, {16'd0, frozen_pc});
    chk("h_no_valid", {31'd0, saw_valid}, 32'd0);
`else
    frozen_pc = 16'd0;
    saw_valid = 1'b0;
    step();
    expect_out("h_cont4", 16'h0004);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
